// File: rtl/mux8way_arbiter.sv
// mux8way_arbiter
// Eight-source to one-sink registered merge stage. Each cycle one valid
// source is granted, its word is captured into a single output register,
// and the winning index is reported on out_sel (same 3-bit encoding the
// 8-way demultiplexer consumes). Sustains one word per cycle.
//
// Build option:
//   MUX8WAY_FIXED_PRIO_EN defined   -> fixed priority, lowest index wins,
//                                      no rotation pointer.
//   MUX8WAY_FIXED_PRIO_EN undefined -> round-robin starting after the
//                                      last granted source.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-high reset
//   in_valid   in   [7:0] per-source valid
//   in_data    in   [8*WIDTH-1:0] source i at [i*WIDTH +: WIDTH]
//   in_ready   out  [7:0] per-source accept, at most one bit set
//   out_valid  out  output register holds a word
//   out_data   out  [WIDTH-1:0] registered word
//   out_sel    out  [2:0] index of the source that produced out_data
//   out_ready  in   consumer accepts the word

module mux8way_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         in_valid,
  input  logic [8*WIDTH-1:0] in_data,
  output logic [7:0]         in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [2:0]         out_sel,
  input  logic               out_ready
);

  logic [WIDTH-1:0] words [8];
  logic             can_load;
  logic             found;
  logic [2:0]       grant_idx;
  logic             src_xfer;

  for (genvar i = 0; i < 8; i++) begin : g_unpack
    assign words[i] = in_data[i*WIDTH +: WIDTH];
  end

  assign can_load = ~out_valid | out_ready;

`ifdef MUX8WAY_FIXED_PRIO_EN

  // Scan from the top down so the lowest valid index is the last to write.
  always_comb begin
    found     = 1'b0;
    grant_idx = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (in_valid[k]) begin
        found     = 1'b1;
        grant_idx = 3'(k);
      end
    end
  end

`else

  logic [2:0] ptr;

  // Search ptr+1, ptr+2, ... wrapping; ptr itself is examined last
  // (k = 8 wraps to offset 0), so a lone requester is always served.
  always_comb begin
    logic [2:0] idx;
    found     = 1'b0;
    grant_idx = 3'd0;
    idx       = 3'd0;
    for (int k = 1; k <= 8; k++) begin
      idx = ptr + 3'(k);
      if (!found && in_valid[idx]) begin
        found     = 1'b1;
        grant_idx = idx;
      end
    end
  end

  // Reset value 7 makes the first search begin at source 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= 3'd7;
    end else if (src_xfer) begin
      ptr <= grant_idx;
    end
  end

`endif

  // Grant depends only on valids and out_ready, never on data.
  // Gated by reset so nothing is offered while the stage is held in reset.
  always_comb begin
    in_ready = 8'b0;
    if (!reset && can_load && found) begin
      in_ready = 8'b1 << grant_idx;
    end
  end

  assign src_xfer = |in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= 3'd0;
    end else if (src_xfer) begin
      // Also covers a simultaneous drain: overwrite without a bubble.
      out_valid <= 1'b1;
      out_data  <= words[grant_idx];
      out_sel   <= grant_idx;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux8way_arbiter.sv
module tb_mux8way_arbiter;

  localparam int WIDTH = 16;

  logic               clk;
  logic               reset;
  logic [7:0]         in_valid;
  logic [8*WIDTH-1:0] in_data;
  logic [7:0]         in_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [2:0]         out_sel;
  logic               out_ready;

  int checks;
  int failures;

  mux8way_arbiter #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic load_counting_words();
    for (int i = 0; i < 8; i++) in_data[i*WIDTH +: WIDTH] = 16'h1000 + 16'(i);
  endtask

  // Pulse reset, release on a falling edge; returns mid-cycle with no
  // rising edge seen since release. Callers set inputs beforehand.
  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 8'hFF; out_ready = 1'b0;
    load_counting_words();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got %b expected 0", out_valid); end
    checks++; if (out_data !== 16'h0) begin failures++; $display("FAIL reset_out_data got %h expected 0000", out_data); end
    checks++; if (out_sel !== 3'd0) begin failures++; $display("FAIL reset_out_sel got %0d expected 0", out_sel); end
    checks++; if (in_ready !== 8'h00) begin failures++; $display("FAIL reset_in_ready got %h expected 00", in_ready); end
    out_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (in_ready !== 8'h01) begin failures++; $display("FAIL reset_first_grant got %h expected 01", in_ready); end
    @(posedge clk); #1;
    checks++; if (out_sel !== 3'd0 || out_valid !== 1'b1) begin failures++; $display("FAIL reset_first_word got sel=%0d valid=%b expected sel=0 valid=1", out_sel, out_valid); end
    checks++; if (out_data !== 16'h1000) begin failures++; $display("FAIL reset_first_data got %h expected 1000", out_data); end
  endtask

  task automatic test_rotation();
    logic [7:0] exp_rdy;
    logic [2:0] exp_sel;
    in_valid = 8'hFF; out_ready = 1'b1;
    load_counting_words();
    do_reset();
    for (int c = 0; c < 16; c++) begin
      exp_sel = 3'(c % 8);
      exp_rdy = 8'b1 << exp_sel;
      checks++; if (in_ready !== exp_rdy) begin failures++; $display("FAIL rr_in_ready cycle %0d got %h expected %h", c, in_ready, exp_rdy); end
      @(posedge clk); #1;
      checks++; if (out_sel !== exp_sel || out_valid !== 1'b1) begin failures++; $display("FAIL rr_out_sel cycle %0d got sel=%0d valid=%b expected sel=%0d valid=1", c, out_sel, out_valid, exp_sel); end
      checks++; if (out_data !== 16'h1000 + 16'(exp_sel)) begin failures++; $display("FAIL rr_out_data cycle %0d got %h expected %h", c, out_data, 16'h1000 + 16'(exp_sel)); end
    end
  endtask

  task automatic test_backpressure();
    in_valid = 8'h20; out_ready = 1'b0;
    load_counting_words();
    in_data[5*WIDTH +: WIDTH] = 16'hBEEF;
    do_reset();
    checks++; if (in_ready !== 8'h20) begin failures++; $display("FAIL bp_first_grant got %h expected 20", in_ready); end
    @(posedge clk); #1;
    for (int c = 0; c < 4; c++) begin
      checks++; if (out_valid !== 1'b1 || out_data !== 16'hBEEF || out_sel !== 3'd5) begin failures++; $display("FAIL bp_hold cycle %0d got valid=%b data=%h sel=%0d expected valid=1 data=beef sel=5", c, out_valid, out_data, out_sel); end
      checks++; if (in_ready !== 8'h00) begin failures++; $display("FAIL bp_in_ready cycle %0d got %h expected 00", c, in_ready); end
      @(posedge clk); #1;
    end
    in_data[5*WIDTH +: WIDTH] = 16'hCAFE;
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 8'h20) begin failures++; $display("FAIL bp_release_grant got %h expected 20", in_ready); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1 || out_data !== 16'hCAFE || out_sel !== 3'd5) begin failures++; $display("FAIL bp_no_bubble got valid=%b data=%h sel=%0d expected valid=1 data=cafe sel=5", out_valid, out_data, out_sel); end
    in_valid = 8'h00;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || out_data !== 16'hCAFE) begin failures++; $display("FAIL bp_drain got valid=%b data=%h expected valid=0 data=cafe", out_valid, out_data); end
  endtask

  task automatic test_sparse_wrap();
    in_valid = 8'h40; out_ready = 1'b1;
    load_counting_words();
    do_reset();
    @(posedge clk); #1;
    checks++; if (out_sel !== 3'd6) begin failures++; $display("FAIL wrap_setup got sel=%0d expected 6", out_sel); end
    in_valid = 8'h84;
    #1;
    checks++; if (in_ready !== 8'h80) begin failures++; $display("FAIL wrap_grant7 got %h expected 80", in_ready); end
    @(posedge clk); #1;
    checks++; if (out_sel !== 3'd7 || out_data !== 16'h1007) begin failures++; $display("FAIL wrap_sel7 got sel=%0d data=%h expected sel=7 data=1007", out_sel, out_data); end
    checks++; if (in_ready !== 8'h04) begin failures++; $display("FAIL wrap_grant2 got %h expected 04", in_ready); end
    @(posedge clk); #1;
    checks++; if (out_sel !== 3'd2 || out_data !== 16'h1002) begin failures++; $display("FAIL wrap_sel2 got sel=%0d data=%h expected sel=2 data=1002", out_sel, out_data); end
  endtask

  task automatic test_reset_midstream();
    in_valid = 8'h08; out_ready = 1'b0;
    load_counting_words();
    do_reset();
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1 || out_sel !== 3'd3) begin failures++; $display("FAIL mid_setup got valid=%b sel=%0d expected valid=1 sel=3", out_valid, out_sel); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || out_data !== 16'h0) begin failures++; $display("FAIL mid_async_clear got valid=%b data=%h expected valid=0 data=0000", out_valid, out_data); end
    checks++; if (in_ready !== 8'h00) begin failures++; $display("FAIL mid_in_ready got %h expected 00", in_ready); end
    in_valid = 8'hFF; out_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (in_ready !== 8'h01) begin failures++; $display("FAIL mid_restart_grant got %h expected 01", in_ready); end
    @(posedge clk); #1;
    checks++; if (out_sel !== 3'd0 || out_valid !== 1'b1) begin failures++; $display("FAIL mid_restart_sel got sel=%0d valid=%b expected sel=0 valid=1", out_sel, out_valid); end
  endtask

  task automatic test_fixed_prio();
    in_valid = 8'hFF; out_ready = 1'b1;
    load_counting_words();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      checks++; if (out_sel !== 3'd0 || out_data !== 16'h1000) begin failures++; $display("FAIL fixed_sel0 cycle %0d got sel=%0d data=%h expected sel=0 data=1000", c, out_sel, out_data); end
    end
    in_valid = 8'hFE;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      checks++; if (out_sel !== 3'd1 || out_data !== 16'h1001) begin failures++; $display("FAIL fixed_sel1 cycle %0d got sel=%0d data=%h expected sel=1 data=1001", c, out_sel, out_data); end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    in_valid = 8'h00;
    in_data = '0;
    out_ready = 1'b0;
    test_reset();
`ifdef MUX8WAY_FIXED_PRIO_EN
    test_fixed_prio();
`else
    test_rotation();
    test_backpressure();
    test_sparse_wrap();
    test_reset_midstream();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux8way_arbiter.md
# mux8way_arbiter

Eight-source to one-sink registered merge stage: the gather counterpart of the 8-way demultiplexer that scatters one stream across eight destinations by a 3-bit select. Each cycle it picks one valid source, latches its word into a single output register, and reports the winning index on `out_sel`, with the same encoding the 8-way demultiplexer consumes. It sits between eight word producers (memory banks, I/O devices) and a single consumer such as the CPU data bus. Sustains one word per cycle.

## Interface
- `WIDTH`, 16, data word width (HACK word)
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high reset
- `in_valid`  in  8  per-source valid; bit i = source i
- `in_data`  in  8*WIDTH  flattened words; source i at `[i*WIDTH +: WIDTH]`
- `in_ready`  out  8  per-source accept; at most one bit set
- `out_valid`  out  1  output register holds a word
- `out_data`  out  WIDTH  registered word
- `out_sel`  out  3  index of the source that produced `out_data`
- `out_ready`  in  1  consumer accepts the word

## Operation
- Transfer on source i: `in_valid[i] & in_ready[i]` at a rising edge. Transfer on output: `out_valid & out_ready`.
- `can_load = ~out_valid | out_ready` (register empty, or draining this cycle).
- Grant (combinational): when `can_load` and `|in_valid`, exactly one winner g is chosen; `in_ready = can_load ? onehot(g) : 8'b0`. With no valid source, `in_ready = 0`.
- Round-robin (default): search starts at `(ptr + 1) mod 8` and proceeds upward with wrap; first valid source wins. `ptr` is a 3-bit register updated to g on every source transfer, and is unchanged otherwise.
- On a source transfer: `out_data <= in_data[g]`, `out_sel <= g`, `out_valid <= 1`.
- On an output transfer with no source transfer: `out_valid <= 0`; `out_data` and `out_sel` hold their last values.
- Simultaneous output and source transfer: the register is overwritten in the same edge, `out_valid` stays 1, and there is no bubble.
- When `out_valid & ~out_ready`, `out_data` and `out_sel` are stable and all `in_ready` are 0. A source may drop `in_valid` without penalty; an ungranted source never loses data.
- Fairness: a continuously valid source is granted within 8 source transfers.
- `in_ready` does not depend on any `in_data`.

## Timing
- Reset (async assert; values apply immediately): `out_valid=0`, `out_data=0`, `out_sel=0`, `ptr=7`. The first round-robin search therefore starts at source 0. `in_ready=0` during reset.
- Reset deassertion is expected synchronous to `clk`. Reset asserted mid-stream discards the held word and never yields a partial transfer.
- Latency: source transfer at edge N means the word is visible on `out_data` after edge N and can be consumed at edge N+1.
- Throughput: 1 word/cycle while `out_ready=1`.
- Combinational paths: `out_ready` → `in_ready` and `in_valid` → `in_ready` only. All other outputs come directly from registers.

## Configuration
- `MUX8WAY_FIXED_PRIO_EN` defined: fixed priority. The lowest-indexed valid source always wins, and `ptr` is removed (not synthesized). Starvation of high indices is permitted.
- Undefined: round-robin as in Operation.
- Port list and latency are identical in both builds.

## Test plan
- Reset: hold `reset=1` with all `in_valid=8'hFF` → `out_valid=0`, `out_data=0`, `out_sel=0`, `in_ready=0`. Release with `out_ready=1` → first grant is `in_ready=8'h01`, then `out_sel=0` one cycle later.
- Round-robin rotation: all sources valid, `in_data[i]=16'h1000+i`, `out_ready=1` for 16 cycles → `out_sel` sequence is 0,1,…,7,0,…,7 and `out_data` matches each index. Exactly one `in_ready` bit per cycle; no bubbles.
- Backpressure: source 5 only, word `16'hBEEF`, `out_ready=0` for 4 cycles → `out_valid=1`, `out_data=16'hBEEF`, `out_sel=5` held, `in_ready=0`. Raise `out_ready` → the next source-5 word loads on the same edge the old word drains.
- Sparse wrap: after a grant to 6, only sources 2 and 7 valid → 7 is granted, then 2.
- Reset mid-stream: assert `reset` while `out_valid=1` and `out_ready=0` → `out_valid` drops to 0 asynchronously. After release, round-robin restarts at source 0.
- `MUX8WAY_FIXED_PRIO_EN` build: all sources valid, `out_ready=1` → `out_sel=0` every cycle. Drop `in_valid[0]` → `out_sel=1` every cycle.
